// File: rtl/traffic_signal_monitor_if.sv
// Light-bus bundle between the traffic controller (or a bench) and the
// passive traffic_signal_monitor.
//   master : drives the four 3-bit lamp codes m1..m4 and the flag clear clr,
//            observes the monitor's flags, first-error capture and green count.
//   slave  : the monitor side; samples m1..m4/clr and drives the results.
interface traffic_signal_monitor_if;
  logic [2:0] m1;
  logic [2:0] m2;
  logic [2:0] m3;
  logic [2:0] m4;
  logic       clr;
  logic       code_err;
  logic       conflict;
  logic       seq_err;
  logic       timeout;
  logic       err_any;
  logic [1:0] err_road;
  logic [1:0] err_type;
  logic [7:0] green_cnt;

  modport master (
    output m1, m2, m3, m4, clr,
    input  code_err, conflict, seq_err, timeout, err_any,
    input  err_road, err_type, green_cnt
  );

  modport slave (
    input  m1, m2, m3, m4, clr,
    output code_err, conflict, seq_err, timeout, err_any,
    output err_road, err_type, green_cnt
  );
endinterface

// File: rtl/traffic_signal_monitor.sv
// Passive checker for the four-road traffic light bus.
// Decodes each road's 3-bit lamp drive every clock, raises sticky flags for
// invalid codes, conflicting right-of-way, illegal sequencing (including a
// too-short yellow) and stuck green, captures the first error's road/type,
// and counts completed R->G transitions.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - slave side of traffic_signal_monitor_if
//          (m1..m4, clr in; code_err, conflict, seq_err, timeout, err_any,
//           err_road, err_type, green_cnt out)
module traffic_signal_monitor #(
  parameter int CNT_W      = 12,
  parameter int MAX_GREEN  = 1000,
  parameter int MIN_YELLOW = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_signal_monitor_if.slave   bus
);

  localparam logic [1:0] ST_R = 2'd0;
  localparam logic [1:0] ST_Y = 2'd1;
  localparam logic [1:0] ST_G = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic is_legal(input logic [2:0] code);
    return (code == 3'b100) || (code == 3'b010) || (code == 3'b001);
  endfunction

  // Invalid codes decode as RED so they never count toward a conflict.
  function automatic logic [1:0] decode(input logic [2:0] code);
    case (code)
      3'b010:  return ST_Y;
      3'b001:  return ST_G;
      default: return ST_R;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  logic [2:0]       m_p0     [4];
  logic [1:0]       st_p0    [4];
  logic [3:0]       legal_p0;
  logic [3:0]       code_bad_p0;
  logic [3:0]       busy_p0;
  logic [3:0]       seq_bad_p0;
  logic [3:0]       tmo_bad_p0;
  logic [3:0]       rg_p0;
  logic             conf_det_p0;
  logic             det_any_p0;
  logic [1:0]       det_road_p0;
  logic [1:0]       det_type_p0;

  logic [1:0]       prev_p1  [4];
  logic [3:0]       prev_valid_p1;
  logic [CNT_W-1:0] dwell_p1 [4];
  logic             code_err_p1;
  logic             conflict_p1;
  logic             seq_err_p1;
  logic             timeout_p1;
  logic [1:0]       err_road_p1;
  logic [1:0]       err_type_p1;
  logic [7:0]       green_cnt_p1;
  logic             err_any_p1;

  assign m_p0[0] = bus.m1;
  assign m_p0[1] = bus.m2;
  assign m_p0[2] = bus.m3;
  assign m_p0[3] = bus.m4;

  // ---- stage 0: decode current sample and detect errors against history ----
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      legal_p0[i]    = is_legal(m_p0[i]);
      st_p0[i]       = decode(m_p0[i]);
      code_bad_p0[i] = !legal_p0[i];
      busy_p0[i]     = legal_p0[i] && (st_p0[i] != ST_R);
      seq_bad_p0[i]  = 1'b0;
      tmo_bad_p0[i]  = 1'b0;
      rg_p0[i]       = 1'b0;
      if (legal_p0[i] && prev_valid_p1[i]) begin
        case ({prev_p1[i], st_p0[i]})
          {ST_G, ST_R}, {ST_R, ST_Y}, {ST_Y, ST_G}: seq_bad_p0[i] = 1'b1;
          {ST_Y, ST_R}: seq_bad_p0[i] = (dwell_p1[i] < CNT_W'(MIN_YELLOW));
          {ST_R, ST_G}: rg_p0[i] = 1'b1;
          // dwell still holds the green run length before this sample
          {ST_G, ST_G}: tmo_bad_p0[i] = (dwell_p1[i] == CNT_W'(MAX_GREEN));
          default: ;
        endcase
      end
    end

    // two or more bits set
    conf_det_p0 = (busy_p0 & (busy_p0 - 4'd1)) != 4'd0;
    det_any_p0  = (|code_bad_p0) || conf_det_p0 || (|seq_bad_p0) || (|tmo_bad_p0);

    det_type_p0 = 2'd0;
    det_road_p0 = 2'd0;
    if (|code_bad_p0) begin
      det_type_p0 = 2'd0;
      det_road_p0 = lowest(code_bad_p0);
    end else if (conf_det_p0) begin
      det_type_p0 = 2'd1;
      det_road_p0 = lowest(busy_p0);
    end else if (|seq_bad_p0) begin
      det_type_p0 = 2'd2;
      det_road_p0 = lowest(seq_bad_p0);
    end else if (|tmo_bad_p0) begin
      det_type_p0 = 2'd3;
      det_road_p0 = lowest(tmo_bad_p0);
    end
  end

  // ---- stage 1: per-road history (invalid samples leave history untouched) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid_p1 <= '0;
      for (int i = 0; i < 4; i++) dwell_p1[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (legal_p0[i]) begin
          prev_valid_p1[i] <= 1'b1;
          if (!prev_valid_p1[i] || (prev_p1[i] != st_p0[i]))
            dwell_p1[i] <= CNT_W'(1);
          else
            dwell_p1[i] <= sat_inc(dwell_p1[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (legal_p0[i]) prev_p1[i] <= st_p0[i];
  end

  // ---- stage 1: sticky flags, first-error capture, green count ----
  always_ff @(posedge clk) begin
    if (rst) begin
      code_err_p1  <= 1'b0;
      conflict_p1  <= 1'b0;
      seq_err_p1   <= 1'b0;
      timeout_p1   <= 1'b0;
      err_road_p1  <= 2'd0;
      err_type_p1  <= 2'd0;
      green_cnt_p1 <= 8'd0;
    end else begin
      // clr takes effect first, so a same-cycle error is still set/captured
      code_err_p1 <= (code_err_p1 && !bus.clr) || (|code_bad_p0);
      conflict_p1 <= (conflict_p1 && !bus.clr) || conf_det_p0;
      seq_err_p1  <= (seq_err_p1  && !bus.clr) || (|seq_bad_p0);
      timeout_p1  <= (timeout_p1  && !bus.clr) || (|tmo_bad_p0);
      if ((bus.clr || !err_any_p1) && det_any_p0) begin
        err_road_p1 <= det_road_p0;
        err_type_p1 <= det_type_p0;
      end else if (bus.clr) begin
        err_road_p1 <= 2'd0;
        err_type_p1 <= 2'd0;
      end
      green_cnt_p1 <= green_cnt_p1 + 8'(rg_p0[0]) + 8'(rg_p0[1])
                                   + 8'(rg_p0[2]) + 8'(rg_p0[3]);
    end
  end

  assign err_any_p1    = code_err_p1 | conflict_p1 | seq_err_p1 | timeout_p1;
  assign bus.code_err  = code_err_p1;
  assign bus.conflict  = conflict_p1;
  assign bus.seq_err   = seq_err_p1;
  assign bus.timeout   = timeout_p1;
  assign bus.err_any   = err_any_p1;
  assign bus.err_road  = err_road_p1;
  assign bus.err_type  = err_type_p1;
  assign bus.green_cnt = green_cnt_p1;

endmodule
